enc8to3_rr_arb: RTL and testbench
=================================

// Module: enc8to3_rr_arb
// PURPOSE
//  Round-robin 8-to-3 encoding arbiter: collects up to 8 one-hot write requests
//  (e.g. register-file writeback sources) and issues one 3-bit index at a time
//  with a valid/ready handshake. Output idx/valid drive the register-file write
//  decoder (w/enable) directly. Bit convention matches that decoder: index i <-> req[7-i].
// PARAMETERS
//  N      8   number of requesters (fixed at 8; bit mapping assumes it)
//  IDX_W  3   index width, clog2(N)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  req        in   8      request vector; req[7-i] = requester i wants a slot
//  out_valid  out  1      out_idx holds a granted index
//  out_idx    out  3      granted index (0..7)
//  out_ready  in   1      downstream accepts out_idx this cycle
//  gnt        out  8      one-hot accept pulse to requester; gnt[7-i] for index i
//  err        out  1      sticky protocol error (only with ENC_ERR_CHECK_EN)
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, ptr=0, out_valid=0, out_idx=0, err=0;
//    gnt=0 while out_valid=0. Reset mid-grant drops the grant, no gnt pulse.
//  - States: IDLE (out_valid=0), GRANT (out_valid=1).
//  - Arbitration: scan indices ptr, ptr+1, ... (mod 8); first set request wins.
//  - IDLE: if |req, load winner into out_idx, go GRANT (1-cycle req->valid latency).
//    Else stay IDLE.
//  - GRANT: out_idx stable while out_valid=1 and out_ready=0 (no re-arbitration,
//    even if a higher-priority req arrives).
//  - Accept (out_valid & out_ready): gnt = onehot(out_idx) combinationally, same
//    cycle; ptr <= out_idx+1 (wraps 7->0). Re-arbitrate same edge over
//    req & ~onehot(out_idx) from new ptr: if nonzero, load winner, stay GRANT
//    (back-to-back, 1 grant/cycle); else go IDLE.
//  - Requester must drop req the cycle after its gnt; a still-set req in the
//    next cycle counts as a new request.
//  - gnt is 0 whenever no accept occurs. out_ready ignored in IDLE.
//  - Requester withdrawing req while granted: grant is still held until accepted.
// CONFIGURATION
//  - ENC_ERR_CHECK_EN defined: err set (sticky until rst) when, in GRANT, the
//    req bit of out_idx is 0 before accept. Grant behaviour is unchanged.
//  - Not defined: err tied 0, no check logic.
// STRUCTURE
//  - Shared package: N, IDX_W, state enum {IDLE, GRANT}, idx<->bit mapping
//    function (bit = N-1-idx) shared with the register-file decoder.
//  - Sub-module rr_pick8: combinational masked round-robin priority pick
//    (req, ptr) -> (any, idx). Top holds FSM, ptr, out_idx, err.
// TESTING
//  1. rst=1 2 cycles, req=8'hFF -> out_valid=0, gnt=0, err=0 throughout reset.
//  2. ptr=0, req=8'b0010_0000 (idx 2), out_ready=1 -> out_valid next cycle, idx=2,
//     gnt=8'b0010_0000 that cycle, ptr=3, back to IDLE.
//  3. req=8'hFF held, out_ready=1 -> idx sequence 0,1,...,7,0 one per cycle,
//     gnt rotates 8'h80,8'h40,...,8'h01 (wrap check).
//  4. req idx 5 granted, out_ready=0 5 cycles, then req idx 1 added -> idx stays 5;
//     on ready, gnt idx 5, next idx=1 (ptr 6 wraps past 7).
//  5. ENC_ERR_CHECK_EN: grant idx 3, drop its req before ready -> err=1 next cycle,
//     stays 1 after accept until rst; without macro err=0.
//  6. rst asserted during GRANT with out_ready=1 -> no gnt, out_valid=0, ptr=0.

Source files
------------

// File: rtl/enc8to3_rr_arb_pkg.sv
// Shared definitions for the 8-to-3 round-robin encoding arbiter and the
// register-file write decoder: sizes, FSM state codes, and the mapping
// between a 3-bit index and its request/grant bit (bit = N-1-idx).
package enc8to3_rr_arb_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Bit position of index idx in req/gnt vectors.
  function automatic logic [IDX_W-1:0] idx_bit(input logic [IDX_W-1:0] idx);
    return IDX_W'(N - 1) - idx;
  endfunction

  // One-hot vector with the bit belonging to index idx set.
  function automatic logic [N-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] oh;
    oh = '0;
    oh[idx_bit(idx)] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/enc8to3_rr_arb_rr_pick8.sv
// rr_pick8: combinational round-robin pick. Scans indices ptr, ptr+1, ...
// (mod 8) and returns the first index whose request bit is set.
module rr_pick8
  import enc8to3_rr_arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[idx_bit(cand)]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/enc8to3_rr_arb.sv
// enc8to3_rr_arb: round-robin 8-to-3 encoding arbiter with valid/ready output.
// Optional macro ENC_ERR_CHECK_EN enables a sticky error flag raised when the
// granted requester withdraws its request before the grant is accepted.
module enc8to3_rr_arb
  import enc8to3_rr_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
  output logic [N-1:0]     gnt,
  output logic             err
);

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic             accept;
  logic [N-1:0]     cur_oh;
  logic [N-1:0]     pick_req;
  logic [IDX_W-1:0] pick_ptr;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  assign out_valid = (state == ST_GRANT);
  assign cur_oh    = idx_onehot(out_idx);
  // Reset wins over a pending accept: no gnt pulse while rst is high.
  assign accept    = out_valid & out_ready & ~rst;
  assign gnt       = accept ? cur_oh : '0;

  // On accept the next winner is chosen past the accepted index, excluding it.
  assign pick_req  = accept ? (req & ~cur_oh) : req;
  assign pick_ptr  = accept ? (out_idx + IDX_W'(1)) : ptr;

  rr_pick8 u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // FSM, rotating pointer and held grant index.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      out_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            out_idx <= pick_idx;
            state   <= ST_GRANT;
          end
        end
        default: begin
          if (accept) begin
            ptr <= pick_ptr;
            if (pick_any) out_idx <= pick_idx;
            else          state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef ENC_ERR_CHECK_EN
  logic err_q;

  // Sticky flag: granted requester dropped its request while waiting for ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (out_valid && !out_ready && !req[idx_bit(out_idx)]) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_enc8to3_rr_arb.sv
// Self-checking bench for enc8to3_rr_arb: directed scenarios followed by
// randomized traffic, all compared against a behavioural round-robin model.
module tb_enc8to3_rr_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       out_valid;
  logic [2:0] out_idx;
  logic       out_ready;
  logic [7:0] gnt;
  logic       err;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit m_valid;
  int m_idx;
  int m_ptr;
  bit m_err;

  always #5 clk = ~clk;

  enc8to3_rr_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_ready (out_ready),
    .gnt       (gnt),
    .err       (err)
  );

  function automatic logic [7:0] bit_of(input int idx);
    logic [7:0] v;
    v = 8'd1 << (7 - idx);
    return v;
  endfunction

  // First requesting index at or after p, circularly; -1 if none.
  function automatic int first_req(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (p + k) % 8;
      if ((r & bit_of(i)) != 8'd0) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, compare outputs, then advance the model
  // to what the following rising edge must produce.
  task automatic step(input logic [7:0] r, input logic rd, input logic rs);
    logic [7:0] exp_gnt;
    @(negedge clk);
    req       = r;
    out_ready = rd;
    rst       = rs;
    #1;
    exp_gnt = (m_valid && rd && !rs) ? bit_of(m_idx) : 8'd0;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_idx",   32'(out_idx),   32'(m_idx));
    chk("gnt",       32'(gnt),       32'(exp_gnt));
    chk("err",       32'(err),       32'(m_err));

    if (rs) begin
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
      m_err   = 1'b0;
    end else if (!m_valid) begin
      if (r != 8'd0) begin
        m_idx   = first_req(r, m_ptr);
        m_valid = 1'b1;
      end
    end else begin
`ifdef ENC_ERR_CHECK_EN
      if (!rd && ((r & bit_of(m_idx)) == 8'd0)) m_err = 1'b1;
`endif
      if (rd) begin
        int nxt;
        m_ptr = (m_idx + 1) % 8;
        nxt   = first_req(r & ~bit_of(m_idx), m_ptr);
        if (nxt >= 0) m_idx = nxt;
        else          m_valid = 1'b0;
      end
    end
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] last_gnt;
    rst       = 1'b1;
    req       = 8'hFF;
    out_ready = 1'b0;
    m_valid   = 1'b0;
    m_idx     = 0;
    m_ptr     = 0;
    m_err     = 1'b0;
    @(posedge clk);

    // 1. reset held with all requests asserted
    step(8'hFF, 1'b1, 1'b1);
    step(8'hFF, 1'b1, 1'b1);
    chk("rst_valid", 32'(out_valid), 32'd0);

    // 2. single request idx 2, accepted immediately; ptr moves to 3
    step(8'b0010_0000, 1'b1, 1'b0);
    step(8'b0010_0000, 1'b1, 1'b0);
    chk("t2_idx", 32'(out_idx), 32'd2);
    chk("t2_gnt", 32'(gnt), 32'h20);
    step(8'h00, 1'b1, 1'b0);
    chk("t2_idle", 32'(out_valid), 32'd0);
    step(8'hFF, 1'b1, 1'b0);
    step(8'hFF, 1'b0, 1'b0);
    chk("t2_ptr3", 32'(out_idx), 32'd3);

    // 3. all requests held, ready held: full rotation with wrap
    step(8'hFF, 1'b0, 1'b1);
    step(8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b1, 1'b0);
      chk("t3_idx", 32'(out_idx), 32'(i % 8));
    end

    // 4. idx 5 held without ready, idx 1 arrives, no re-arbitration
    step(8'hFF, 1'b0, 1'b1);
    step(8'b0000_0100, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(8'b0000_0100, 1'b0, 1'b0);
    step(8'b0100_0100, 1'b0, 1'b0);
    chk("t4_hold", 32'(out_idx), 32'd5);
    step(8'b0100_0100, 1'b1, 1'b0);
    chk("t4_gnt5", 32'(gnt), 32'h04);
    step(8'b0100_0000, 1'b1, 1'b0);
    chk("t4_idx1", 32'(out_idx), 32'd1);
    step(8'h00, 1'b0, 1'b0);

    // 5. granted idx 3 withdraws before ready
    step(8'h00, 1'b0, 1'b1);
    step(8'b0001_0000, 1'b0, 1'b0);
    step(8'b0001_0000, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0);
`ifdef ENC_ERR_CHECK_EN
    chk("t5_err", 32'(err), 32'd1);
`else
    chk("t5_err", 32'(err), 32'd0);
`endif
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0);
    chk("t5_clr", 32'(err), 32'd0);

    // 6. reset during GRANT with ready high drops the grant
    step(8'h04, 1'b0, 1'b0);
    step(8'h04, 1'b1, 1'b0);
    step(8'h04, 1'b0, 1'b0);
    step(8'hFF, 1'b1, 1'b1);
    chk("t6_nognt", 32'(gnt), 32'd0);
    step(8'hFF, 1'b0, 1'b0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    step(8'hFF, 1'b0, 1'b0);
    chk("t6_ptr0", 32'(out_idx), 32'd0);

    // Randomized traffic; granted requesters mostly drop their bit afterwards
    last_gnt = 8'h00;
    r        = 8'h00;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       r = 8'($urandom);
        1:       r = 8'h00;
        default: r = (r & ~last_gnt) | 8'($urandom & $urandom);
      endcase
      step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
      last_gnt = gnt;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
